// File: rtl/ram_clr_param_if.sv
// Bus bundle for ram_clr_param: write data/address/strobes from the CPU side,
// read data and clear-busy flag back from the RAM.
interface ram_clr_param_if #(
    parameter int WIDTH  = 16,
    parameter int AWIDTH = 6
) ();
    logic [WIDTH-1:0]  in;
    logic [AWIDTH-1:0] addr;
    logic              ld;
    logic              clr;
    logic [WIDTH-1:0]  out;
    logic              busy;

    modport master (output in, addr, ld, clr, input out, busy);
    modport slave  (input in, addr, ld, clr, output out, busy);
endinterface

// File: rtl/ram_clr_param.sv
// Parametrised single-port word RAM with a hardware clear sweep after reset or
// on request, and a selectable combinational or registered read path.
module ram_clr_param #(
    parameter int WIDTH  = 16,
    parameter int AWIDTH = 6,
    parameter int RD_REG = 0
) (
    input logic           clk,
    input logic           rst,
    ram_clr_param_if.slave bus
);
    localparam int DEPTH = 2 ** AWIDTH;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_nx;
    logic [AWIDTH-1:0] cnt, cnt_nx;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic              busy;
    logic              we;
    logic [AWIDTH-1:0] waddr;
    logic [WIDTH-1:0]  wdata;
    logic [WIDTH-1:0]  rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            CLEAR: begin
                if (cnt == '1) state_nx = IDLE;
                else           cnt_nx   = cnt + 1'b1;
            end
            default: begin
                if (bus.clr) begin
                    state_nx = CLEAR;
                    cnt_nx   = '0;
                end
            end
        endcase
    end

    assign busy = (state == CLEAR);

    // The sweep borrows the single write port, so user writes are masked while busy.
    always_comb begin
        we    = busy | (bus.ld & ~bus.clr);
        waddr = busy ? cnt : bus.addr;
        wdata = busy ? '0 : bus.in;
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    generate
        if (RD_REG == 0) begin : g_comb_rd
            always_comb begin
                rdata = busy ? '0 : mem[bus.addr];
            end
        end else begin : g_reg_rd
            always_ff @(posedge clk or posedge rst) begin
                if (rst)       rdata <= '0;
                else if (busy) rdata <= '0;
                else           rdata <= mem[bus.addr];
            end
        end
    endgenerate

    assign bus.out  = rdata;
    assign bus.busy = busy;
endmodule

// File: tb/tb_ram_clr_param.sv
// Directed bench for ram_clr_param: three instances cover combinational read,
// registered read and a wide-depth configuration.
module tb_ram_clr_param;
    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    ram_clr_param_if #(.WIDTH(16), .AWIDTH(3)) b0 ();
    ram_clr_param_if #(.WIDTH(16), .AWIDTH(3)) b1 ();
    ram_clr_param_if #(.WIDTH(8),  .AWIDTH(6)) b2 ();

    ram_clr_param #(.WIDTH(16), .AWIDTH(3), .RD_REG(0)) u_comb (.clk(clk), .rst(rst), .bus(b0));
    ram_clr_param #(.WIDTH(16), .AWIDTH(3), .RD_REG(1)) u_reg  (.clk(clk), .rst(rst), .bus(b1));
    ram_clr_param #(.WIDTH(8),  .AWIDTH(6), .RD_REG(0)) u_wide (.clk(clk), .rst(rst), .bus(b2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n0, n1, n2;
        rst = 1'b1;
        step();
        step();
        compared++;
        if (b0.busy !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_busy got=%b want=1", b0.busy);
        end
        compared++;
        if (b1.out !== 16'h0000) begin
            mismatched++;
            $display("FAIL reset_regout got=%h want=0000", b1.out);
        end
        rst = 1'b0;
        n0 = 0; n1 = 0; n2 = 0;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (n0 == 0 && !b0.busy) n0 = i;
            if (n1 == 0 && !b1.busy) n1 = i;
            if (n2 == 0 && !b2.busy) n2 = i;
            if (n0 != 0 && n1 != 0 && n2 != 0) break;
        end
        compared++;
        if (n0 != 8) begin
            mismatched++;
            $display("FAIL reset_sweep_len got=%0d want=8", n0);
        end
        compared++;
        if (n1 != 8) begin
            mismatched++;
            $display("FAIL reset_sweep_len_reg got=%0d want=8", n1);
        end
        compared++;
        if (n2 != 64) begin
            mismatched++;
            $display("FAIL reset_sweep_len_wide got=%0d want=64", n2);
        end
        for (int a = 0; a < 8; a++) begin
            b0.addr = 3'(a);
            b1.addr = 3'(a);
            step();
            compared++;
            if (b0.out !== 16'h0000) begin
                mismatched++;
                $display("FAIL reset_zero a=%0d got=%h want=0000", a, b0.out);
            end
            compared++;
            if (b1.out !== 16'h0000) begin
                mismatched++;
                $display("FAIL reset_zero_reg a=%0d got=%h want=0000", a, b1.out);
            end
        end
    endtask

    task automatic test_comb_write();
        b0.addr = 3'd5; b0.in = 16'hBEEF; b0.ld = 1'b1;
        step();
        b0.ld = 1'b0;
        compared++;
        if (b0.out !== 16'hBEEF) begin
            mismatched++;
            $display("FAIL comb_write got=%h want=beef", b0.out);
        end
        b0.addr = 3'd4;
        #1;
        compared++;
        if (b0.out !== 16'h0000) begin
            mismatched++;
            $display("FAIL comb_other_addr got=%h want=0000", b0.out);
        end
        b0.addr = 3'd5; b0.in = 16'h1234;
        step();
        compared++;
        if (b0.out !== 16'hBEEF) begin
            mismatched++;
            $display("FAIL comb_no_ld got=%h want=beef", b0.out);
        end
    endtask

    task automatic test_reg_read_first();
        b1.addr = 3'd2; b1.in = 16'hA5A5; b1.ld = 1'b1;
        step();
        b1.in = 16'h5A5A;
        step();
        b1.ld = 1'b0;
        compared++;
        if (b1.out !== 16'hA5A5) begin
            mismatched++;
            $display("FAIL reg_read_first got=%h want=a5a5", b1.out);
        end
        step();
        compared++;
        if (b1.out !== 16'h5A5A) begin
            mismatched++;
            $display("FAIL reg_new_data got=%h want=5a5a", b1.out);
        end
    endtask

    task automatic test_clr();
        int n;
        for (int a = 0; a < 8; a++) begin
            b0.addr = 3'(a); b0.in = 16'h00FF; b0.ld = 1'b1;
            step();
        end
        b0.ld = 1'b0; b0.addr = 3'd3;
        #1;
        compared++;
        if (b0.out !== 16'h00FF) begin
            mismatched++;
            $display("FAIL clr_fill got=%h want=00ff", b0.out);
        end
        b0.clr = 1'b1; b0.ld = 1'b1; b0.in = 16'hFFFF;
        step();
        b0.clr = 1'b0;
        n = 0;
        while (b0.busy === 1'b1 && n < 100) begin
            b0.ld = n[0]; b0.addr = 3'(n); b0.in = 16'hFFFF;
            #1;
            compared++;
            if (b0.out !== 16'h0000) begin
                mismatched++;
                $display("FAIL clr_out_busy n=%0d got=%h want=0000", n, b0.out);
            end
            step();
            n++;
        end
        b0.ld = 1'b0;
        compared++;
        if (n != 8) begin
            mismatched++;
            $display("FAIL clr_busy_len got=%0d want=8", n);
        end
        for (int a = 0; a < 8; a++) begin
            b0.addr = 3'(a);
            #1;
            compared++;
            if (b0.out !== 16'h0000) begin
                mismatched++;
                $display("FAIL clr_zero a=%0d got=%h want=0000", a, b0.out);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        b0.addr = 3'd7; b0.in = 16'h1111; b0.ld = 1'b1;
        step();
        b0.ld = 1'b0; b0.clr = 1'b1;
        step();
        b0.clr = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        #1;
        compared++;
        if (b0.busy !== 1'b1) begin
            mismatched++;
            $display("FAIL midrst_busy got=%b want=1", b0.busy);
        end
        step();
        rst = 1'b0;
        n = 0;
        while (b0.busy === 1'b1 && n < 100) begin
            step();
            n++;
        end
        compared++;
        if (n != 8) begin
            mismatched++;
            $display("FAIL midrst_busy_len got=%0d want=8", n);
        end
        for (int a = 0; a < 8; a++) begin
            b0.addr = 3'(a);
            #1;
            compared++;
            if (b0.out !== 16'h0000) begin
                mismatched++;
                $display("FAIL midrst_zero a=%0d got=%h want=0000", a, b0.out);
            end
        end
    endtask

    task automatic test_wide();
        int n;
        n = 0;
        while (b2.busy === 1'b1 && n < 200) begin
            step();
            n++;
        end
        compared++;
        if (b2.busy !== 1'b0) begin
            mismatched++;
            $display("FAIL wide_idle got=%b want=0", b2.busy);
        end
        b2.addr = 6'd63; b2.in = 8'h3C; b2.ld = 1'b1;
        step();
        b2.addr = 6'd0; b2.in = 8'hC3;
        step();
        b2.ld = 1'b0; b2.addr = 6'd63;
        #1;
        compared++;
        if (b2.out !== 8'h3C) begin
            mismatched++;
            $display("FAIL wide_rd63 got=%h want=3c", b2.out);
        end
        b2.addr = 6'd0;
        #1;
        compared++;
        if (b2.out !== 8'hC3) begin
            mismatched++;
            $display("FAIL wide_rd0 got=%h want=c3", b2.out);
        end
        b2.clr = 1'b1;
        step();
        b2.clr = 1'b0;
        n = 0;
        while (b2.busy === 1'b1 && n < 200) begin
            step();
            n++;
        end
        compared++;
        if (n != 64) begin
            mismatched++;
            $display("FAIL wide_busy_len got=%0d want=64", n);
        end
        #1;
        compared++;
        if (b2.out !== 8'h00) begin
            mismatched++;
            $display("FAIL wide_zero0 got=%h want=00", b2.out);
        end
        b2.addr = 6'd63;
        #1;
        compared++;
        if (b2.out !== 8'h00) begin
            mismatched++;
            $display("FAIL wide_zero63 got=%h want=00", b2.out);
        end
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        rst = 1'b1;
        b0.in = '0; b0.addr = '0; b0.ld = 1'b0; b0.clr = 1'b0;
        b1.in = '0; b1.addr = '0; b1.ld = 1'b0; b1.clr = 1'b0;
        b2.in = '0; b2.addr = '0; b2.ld = 1'b0; b2.clr = 1'b0;
        test_reset();
        test_comb_write();
        test_reg_read_first();
        test_clr();
        test_reset_mid_clear();
        test_wide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
